sm83_oam_dma_arb: RTL
=====================

// Module: sm83_oam_dma_arb
// PURPOSE
//   OAM DMA engine plus external-bus arbiter between the SM83 core and the DMA.
//   - Sits between the core's bus interface (address/data/n_rd/n_wr) and the external memory bus.
//   - A write to the DMA register copies OAM_LEN bytes from {src_hi,8'h00} into OAM, one byte per M-cycle.
//   - While a transfer is in progress, core accesses outside page FFxx are fenced off.
// PARAMETERS
//   ADR_WIDTH    16   address bus width
//   WORD_SIZE    8    data word width
//   OAM_LEN      160  bytes per transfer (OAM size)
//   START_DELAY  1    M-cycles from the register write to the first transfer cycle
// PORTS
//   clk            in   1          clock, one T-state per cycle
//   reset          in   1          synchronous, active-high
//   t1,t2,t3,t4    in   1 each     one-hot T-state strobes
//   reg_we         in   1          DMA register write; valid only at t4
//   reg_wdata      in   WORD_SIZE  source page written
//   reg_rdata      out  WORD_SIZE  last value written; reset 8'h00
//   cpu_adr        in   ADR_WIDTH  core address
//   cpu_rd         in   1          core read request for the current M-cycle
//   cpu_wr         in   1          core write request for the current M-cycle
//   cpu_wdata      in   WORD_SIZE  core write data
//   cpu_rdata      out  WORD_SIZE  data returned to the core
//   ext_adr        out  ADR_WIDTH  external bus address
//   ext_rd         out  1          external bus read
//   ext_wr         out  1          external bus write
//   ext_wdata      out  WORD_SIZE  external bus write data
//   ext_rdata      in   WORD_SIZE  external bus read data
//   oam_adr        out  8          OAM write index
//   oam_wdata      out  WORD_SIZE  OAM write data
//   oam_we         out  1          OAM write strobe, one clk wide
//   dma_active     out  1          transfer pending or running; fences the core
// BEHAVIOUR
//   - Reset values: state=IDLE, idx=0, dly=0, src_hi=0, dma_active=0, oam_we=0, ext_rd=0, ext_wr=0;
//     ext_adr follows cpu_adr.
//   - States and transitions (all evaluated only at t4, except reset):
//     - IDLE: reg_we -> DELAY; dly=START_DELAY-1; src_hi=reg_wdata.
//     - DELAY: dly==0 -> RUN with idx=0; otherwise dly--.
//     - RUN: each M-cycle transfers byte idx; idx==OAM_LEN-1 -> IDLE; otherwise idx++.
//     - reg_we in DELAY or RUN: restart. Go to DELAY, idx=0, new src_hi.
//       dma_active stays 1 if the restart came from RUN.
//   - dma_active: 1 in RUN and in a DELAY entered from RUN; 0 in IDLE and in a DELAY entered from IDLE.
//   - Source mapping: src_hi>=8'hE0 uses page src_hi-8'h20 (echo onto WRAM). No other remapping.
//   - RUN cycle, whole M-cycle t1..t4:
//     - ext_adr={page,idx[7:0]}, ext_rd=1, ext_wr=0.
//     - oam_we=t4, oam_adr=idx, oam_wdata=ext_rdata; same-cycle capture, no extra latency.
//   - Core when dma_active=0: transparent pass-through.
//     ext_adr=cpu_adr, ext_rd=cpu_rd, ext_wr=cpu_wr, ext_wdata=cpu_wdata, cpu_rdata=ext_rdata.
//   - Core when dma_active=1:
//     - cpu_adr[15:8]==8'hFF: access is served combinationally on a side path.
//       This block forwards it unaltered: ext_* carry DMA, and the core's FFxx decode handles IO/HRAM.
//     - Any other address: reads return {WORD_SIZE{1'b1}}; writes are dropped. Never stalled.
//   - Register write and last transfer in the same t4: the restart wins and oam_we still fires for that last byte.
//   - Reset mid-transfer: abort immediately, no further oam_we, reg_rdata=0.
//   - reg_we outside t4 is ignored.
// STRUCTURE
//   - Shared package sm83_pkg:
//     - typedef enum logic [1:0] {DMA_IDLE, DMA_DELAY, DMA_RUN} dma_state_t;
//     - localparam ECHO_BASE=8'hE0, HI_PAGE=8'hFF.
//   - One sub-module, sm83_dma_seq: state register, dly/idx counters, src_hi.
//     Outputs state, idx, page, active.
//   - The arbiter mux (ext_*, cpu_rdata fencing) stays in the top level, purely combinational.
// TESTING
//   1. reg_we=8'hC1 at t4, ext_rdata=idx^8'h5A: after 1 M-cycle delay, 160 oam_we pulses;
//      oam_adr 0..159, ext_adr C100..C19F; dma_active falls after the 160th t4.
//   2. reg_we=8'hE3: ext_adr runs C300..C39F.
//   3. cpu_rd at 16'hC000 during RUN -> cpu_rdata=8'hFF and ext_adr shows the DMA address.
//      cpu_wr at 16'hFF90 -> forwarded; cpu_wr at 16'h8000 -> ext_wr stays 0.
//   4. Restart at idx=50 with 8'hD0: one delay M-cycle with dma_active=1 held,
//      then idx restarts at 0 from D000.
//   5. reset asserted at idx=80 -> next clk: state IDLE, dma_active=0, no further oam_we, reg_rdata=0.
//   6. reg_we pulsed at t2 -> ignored; state stays IDLE.

Source files
------------

// File: rtl/sm83_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm83_pkg
// Description : Shared types and constants for the SM83 OAM DMA / bus arbiter.
// Revision    : 1.0
// ============================================================================
package sm83_pkg;

    typedef enum logic [1:0] {
        DMA_IDLE  = 2'd0,
        DMA_DELAY = 2'd1,
        DMA_RUN   = 2'd2
    } dma_state_t;

    localparam logic [7:0] ECHO_BASE   = 8'hE0;
    localparam logic [7:0] HI_PAGE     = 8'hFF;
    localparam logic [7:0] ECHO_OFFSET = 8'h20;

    // Source pages E0..FF mirror work RAM at C0..DF.
    function automatic logic [7:0] map_page(input logic [7:0] hi);
        return (hi >= ECHO_BASE) ? (hi - ECHO_OFFSET) : hi;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sm83_dma_seq.sv
`default_nettype none
// ============================================================================
// Module      : sm83_dma_seq
// Description : OAM DMA sequencer: state, start delay, byte index, source page.
// Revision    : 1.0
// ============================================================================
module sm83_dma_seq
    import sm83_pkg::*;
#(
    parameter int OAM_LEN     = 160,
    parameter int START_DELAY = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       t4,
    input  logic       reg_we,
    input  logic [7:0] reg_wdata,
    output dma_state_t state,
    output logic [7:0] idx,
    output logic [7:0] page,
    output logic [7:0] src_hi,
    output logic       active
);

    localparam int               c_DLY_W    = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
    localparam logic [c_DLY_W-1:0] c_DLY_INIT = c_DLY_W'(START_DELAY - 1);
    localparam logic [7:0]       c_IDX_LAST = 8'(OAM_LEN - 1);

    dma_state_t          r_state, w_state_nxt;
    logic [c_DLY_W-1:0]  r_dly, w_dly_nxt;
    logic [7:0]          r_idx, w_idx_nxt;
    logic [7:0]          r_src_hi, w_src_hi_nxt;
    logic                r_active, w_active_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= DMA_IDLE;
            r_dly    <= '0;
            r_idx    <= '0;
            r_src_hi <= '0;
            r_active <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_dly    <= w_dly_nxt;
            r_idx    <= w_idx_nxt;
            r_src_hi <= w_src_hi_nxt;
            r_active <= w_active_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_dly_nxt    = r_dly;
        w_idx_nxt    = r_idx;
        w_src_hi_nxt = r_src_hi;
        w_active_nxt = r_active;
        if (t4) begin
            if (reg_we) begin
                // A restart keeps the core fenced if it was already fenced.
                w_state_nxt  = DMA_DELAY;
                w_dly_nxt    = c_DLY_INIT;
                w_idx_nxt    = '0;
                w_src_hi_nxt = reg_wdata;
                w_active_nxt = (r_state == DMA_IDLE) ? 1'b0 : r_active;
            end else begin
                case (r_state)
                    DMA_IDLE: begin
                        w_active_nxt = 1'b0;
                    end
                    DMA_DELAY: begin
                        if (r_dly == '0) begin
                            w_state_nxt  = DMA_RUN;
                            w_idx_nxt    = '0;
                            w_active_nxt = 1'b1;
                        end else begin
                            w_dly_nxt = r_dly - 1'b1;
                        end
                    end
                    DMA_RUN: begin
                        if (r_idx == c_IDX_LAST) begin
                            w_state_nxt  = DMA_IDLE;
                            w_idx_nxt    = '0;
                            w_active_nxt = 1'b0;
                        end else begin
                            w_idx_nxt = r_idx + 8'd1;
                        end
                    end
                    default: begin
                        w_state_nxt  = DMA_IDLE;
                        w_active_nxt = 1'b0;
                    end
                endcase
            end
        end
    end

    assign state  = r_state;
    assign idx    = r_idx;
    assign page   = map_page(r_src_hi);
    assign src_hi = r_src_hi;
    assign active = r_active;

endmodule
`default_nettype wire

// File: rtl/sm83_oam_dma_arb.sv
`default_nettype none
// ============================================================================
// Module      : sm83_oam_dma_arb
// Description : OAM DMA engine and external-bus arbiter between core and DMA.
// Revision    : 1.0
// ============================================================================
module sm83_oam_dma_arb
    import sm83_pkg::*;
#(
    parameter int ADR_WIDTH   = 16,
    parameter int WORD_SIZE   = 8,
    parameter int OAM_LEN     = 160,
    parameter int START_DELAY = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 t1,
    input  logic                 t2,
    input  logic                 t3,
    input  logic                 t4,
    input  logic                 reg_we,
    input  logic [WORD_SIZE-1:0] reg_wdata,
    output logic [WORD_SIZE-1:0] reg_rdata,
    input  logic [ADR_WIDTH-1:0] cpu_adr,
    input  logic                 cpu_rd,
    input  logic                 cpu_wr,
    input  logic [WORD_SIZE-1:0] cpu_wdata,
    output logic [WORD_SIZE-1:0] cpu_rdata,
    output logic [ADR_WIDTH-1:0] ext_adr,
    output logic                 ext_rd,
    output logic                 ext_wr,
    output logic [WORD_SIZE-1:0] ext_wdata,
    input  logic [WORD_SIZE-1:0] ext_rdata,
    output logic [7:0]           oam_adr,
    output logic [WORD_SIZE-1:0] oam_wdata,
    output logic                 oam_we,
    output logic                 dma_active
);

    dma_state_t w_state;
    logic [7:0] w_idx;
    logic [7:0] w_page;
    logic [7:0] w_src_hi;
    logic       w_active;
    logic       w_run;
    logic       w_hi_page;

    sm83_dma_seq #(
        .OAM_LEN     (OAM_LEN),
        .START_DELAY (START_DELAY)
    ) u_seq (
        .clk       (clk),
        .reset     (reset),
        .t4        (t4),
        .reg_we    (reg_we),
        .reg_wdata (reg_wdata[7:0]),
        .state     (w_state),
        .idx       (w_idx),
        .page      (w_page),
        .src_hi    (w_src_hi),
        .active    (w_active)
    );

    assign w_run      = (w_state == DMA_RUN);
    assign w_hi_page  = (cpu_adr[ADR_WIDTH-1 -: 8] == HI_PAGE);
    assign reg_rdata  = WORD_SIZE'(w_src_hi);
    assign dma_active = w_active;

    always_comb begin
        ext_adr   = cpu_adr;
        ext_rd    = cpu_rd;
        ext_wr    = cpu_wr;
        ext_wdata = cpu_wdata;
        cpu_rdata = ext_rdata;
        oam_adr   = w_idx;
        oam_wdata = ext_rdata;
        oam_we    = 1'b0;
        if (w_active) begin
            // FFxx is served by the core's own IO/HRAM decode; everything else is fenced.
            ext_adr = ADR_WIDTH'({w_page, w_idx});
            ext_rd  = 1'b0;
            ext_wr  = 1'b0;
            if (!w_hi_page) begin
                cpu_rdata = {WORD_SIZE{1'b1}};
            end
        end
        if (w_run) begin
            ext_adr = ADR_WIDTH'({w_page, w_idx});
            ext_rd  = t1 | t2 | t3 | t4;
            ext_wr  = 1'b0;
            oam_we  = t4;
        end
    end

endmodule
`default_nettype wire
